// File: rtl/wb_master_pkg.sv
// rtl/wb_master_pkg.sv - shared types and bus widths for the Wishbone command master
package wb_master_pkg;

  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wb_state_e;

endpackage

// File: rtl/wb_timeout_cnt.sv
// rtl/wb_timeout_cnt.sv - bus-phase cycle counter flagging the last allowed wait cycle
module wb_timeout_cnt #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == LAST);

endmodule

// File: rtl/wb_master_ctrl.sv
// rtl/wb_master_ctrl.sv - single-outstanding command/response to Wishbone classic initiator
module wb_master_ctrl
  import wb_master_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_we,
  input  logic [WB_SEL_W-1:0] cmd_sel,
  input  logic [WB_ADR_W-1:0] cmd_adr,
  input  logic [WB_DAT_W-1:0] cmd_dat,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [WB_DAT_W-1:0] rsp_dat,
  output logic                rsp_err,
  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  output logic                wbm_we_o,
  output logic [WB_SEL_W-1:0] wbm_sel_o,
  output logic [WB_ADR_W-1:0] wbm_adr_o,
  output logic [WB_DAT_W-1:0] wbm_dat_o,
  input  logic                wbm_ack_i,
  input  logic [WB_DAT_W-1:0] wbm_dat_i
);

  wb_state_e           state_q, state_d;
  logic                cyc_q, cyc_d;
  logic                we_q, we_d;
  logic [WB_SEL_W-1:0] sel_q, sel_d;
  logic [WB_ADR_W-1:0] adr_q, adr_d;
  logic [WB_DAT_W-1:0] dat_q, dat_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [WB_DAT_W-1:0] rsp_dat_q, rsp_dat_d;
  logic                rsp_err_q, rsp_err_d;
  logic                cnt_clr, cnt_en, cnt_expire;

  wb_timeout_cnt #(
    .CNT_W  (CNT_W),
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk_i   (wb_clk_i),
    .rst_ni  (wb_rst_ni),
    .clr_i   (cnt_clr),
    .en_i    (cnt_en),
    .expire_o(cnt_expire)
  );

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          we_d    = cmd_we;
          sel_d   = cmd_sel;
          adr_d   = cmd_adr;
          dat_d   = cmd_dat;
          cnt_clr = 1'b1;
          cyc_d   = 1'b1;
          state_d = BUS;
        end
      end
      BUS: begin
        cnt_en = !wbm_ack_i;
        // An ack arriving on the expiry cycle still completes the transfer cleanly.
        if (wbm_ack_i) begin
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_dat_d   = we_q ? '0 : wbm_dat_i;
          state_d     = RESP;
        end else if (cnt_expire) begin
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_dat_d   = '0;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        cyc_d       = 1'b0;
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q     <= IDLE;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_dat   = rsp_dat_q;
  assign rsp_err   = rsp_err_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = sel_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;

endmodule

// File: tb/tb_wb_master_ctrl.sv
// tb/tb_wb_master_ctrl.sv - directed scoreboard bench for wb_master_ctrl
module tb_wb_master_ctrl;

  typedef struct {
    logic        err;
    logic [31:0] dat;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [3:0]  cmd_sel;
  logic [31:0] cmd_adr, cmd_dat;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_dat;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;

  int   checks = 0;
  int   failures = 0;
  rsp_t sb[$];

  wb_master_ctrl #(.TIMEOUT(4), .CNT_W(16)) dut (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_we   (cmd_we),
    .cmd_sel  (cmd_sel),
    .cmd_adr  (cmd_adr),
    .cmd_dat  (cmd_dat),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_dat  (rsp_dat),
    .rsp_err  (rsp_err),
    .wbm_cyc_o(wbm_cyc_o),
    .wbm_stb_o(wbm_stb_o),
    .wbm_we_o (wbm_we_o),
    .wbm_sel_o(wbm_sel_o),
    .wbm_adr_o(wbm_adr_o),
    .wbm_dat_o(wbm_dat_o),
    .wbm_ack_i(wbm_ack_i),
    .wbm_dat_i(wbm_dat_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                        input logic [31:0] dat, input logic push, input logic exp_err,
                        input logic [31:0] exp_dat);
    rsp_t e;
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_sel   = sel;
    cmd_adr   = adr;
    cmd_dat   = dat;
    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    if (push) begin
      e.err = exp_err;
      e.dat = exp_dat;
      sb.push_back(e);
    end
    tick();
    cmd_valid = 1'b0;
    check("cyc_rise", 32'(wbm_cyc_o), 32'd1);
    check("stb_rise", 32'(wbm_stb_o), 32'd1);
    check("we_o", 32'(wbm_we_o), 32'(we));
    check("sel_o", 32'(wbm_sel_o), 32'(sel));
    check("dat_o", wbm_dat_o, dat);
  endtask

  task automatic bus_phase(input int ack_at, input logic [31:0] rdata, input logic [31:0] adr,
                           input int exp_cycles);
    int n = 0;
    while (wbm_cyc_o === 1'b1 && n < 20) begin
      n++;
      check("adr_stable", wbm_adr_o, adr);
      wbm_ack_i = (n == ack_at);
      wbm_dat_i = rdata;
      tick();
    end
    wbm_ack_i = 1'b0;
    check("bus_cycles", 32'(n), 32'(exp_cycles));
    check("cyc_fall", 32'(wbm_cyc_o), 32'd0);
    check("rsp_valid_rise", 32'(rsp_valid), 32'd1);
  endtask

  task automatic take_rsp(input int hold, input logic stray);
    rsp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL sb_empty got=0 exp=1");
      return;
    end
    e = sb.pop_front();
    for (int i = 0; i < hold; i++) begin
      rsp_ready = 1'b0;
      cmd_valid = 1'b1;
      wbm_ack_i = stray;
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_dat", rsp_dat, e.dat);
      check("hold_err", 32'(rsp_err), 32'(e.err));
      check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
      check("hold_no_cyc", 32'(wbm_cyc_o), 32'd0);
      tick();
    end
    cmd_valid = 1'b0;
    wbm_ack_i = 1'b0;
    check("rsp_valid", 32'(rsp_valid), 32'd1);
    check("rsp_dat", rsp_dat, e.dat);
    check("rsp_err", 32'(rsp_err), 32'(e.err));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    check("back_idle", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    int accepts, resps;
    rsp_t e;
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_sel = '0; cmd_adr = '0; cmd_dat = '0;
    rsp_ready = 1'b0; wbm_ack_i = 1'b0; wbm_dat_i = '0;
    tick();
    tick();
    check("rst_cyc", 32'(wbm_cyc_o), 32'd0);
    check("rst_stb", 32'(wbm_stb_o), 32'd0);
    check("rst_we", 32'(wbm_we_o), 32'd0);
    check("rst_sel", 32'(wbm_sel_o), 32'd0);
    check("rst_adr", wbm_adr_o, 32'd0);
    check("rst_dat_o", wbm_dat_o, 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_dat", rsp_dat, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    #3 rst_n = 1'b1;
    tick();
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // write, ack on second bus cycle
    accept(1'b1, 4'hF, 32'h3000_0004, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0);
    bus_phase(2, 32'hFFFF_FFFF, 32'h3000_0004, 2);
    take_rsp(0, 1'b0);
    check("adr_hold_idle", wbm_adr_o, 32'h3000_0004);

    // read, ack on first bus cycle
    accept(1'b0, 4'h3, 32'h3000_0000, 32'h0, 1'b1, 1'b0, 32'h1234_5678);
    bus_phase(1, 32'h1234_5678, 32'h3000_0000, 1);
    take_rsp(0, 1'b0);

    // timeout with no ack
    accept(1'b0, 4'hF, 32'h4000_0010, 32'h0, 1'b1, 1'b1, 32'h0);
    bus_phase(0, 32'hA5A5_A5A5, 32'h4000_0010, 4);
    take_rsp(0, 1'b0);

    // ack on the expiry cycle wins
    accept(1'b0, 4'hF, 32'h4000_0020, 32'h0, 1'b1, 1'b0, 32'hCAFE_0001);
    bus_phase(4, 32'hCAFE_0001, 32'h4000_0020, 4);
    take_rsp(0, 1'b0);

    // backpressure on response with stray acks and a pending command
    accept(1'b0, 4'h1, 32'h5000_0000, 32'h0, 1'b1, 1'b0, 32'h0BAD_F00D);
    bus_phase(1, 32'h0BAD_F00D, 32'h5000_0000, 1);
    take_rsp(5, 1'b1);

    // stray ack in IDLE
    wbm_ack_i = 1'b1;
    wbm_dat_i = 32'h7777_7777;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_ack_ready", 32'(cmd_ready), 32'd1);
      check("idle_ack_cyc", 32'(wbm_cyc_o), 32'd0);
      check("idle_ack_rsp", 32'(rsp_valid), 32'd0);
    end
    wbm_ack_i = 1'b0;

    // reset pulse mid-BUS aborts without a response
    accept(1'b1, 4'hF, 32'h6000_0000, 32'h1111_2222, 1'b0, 1'b0, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    check("abort_cyc", 32'(wbm_cyc_o), 32'd0);
    check("abort_stb", 32'(wbm_stb_o), 32'd0);
    check("abort_rsp", 32'(rsp_valid), 32'd0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("post_rst_rsp", 32'(rsp_valid), 32'd0);
      check("post_rst_ready", 32'(cmd_ready), 32'd1);
    end
    accept(1'b0, 4'hF, 32'h6000_0004, 32'h0, 1'b1, 1'b0, 32'h2468_ACE0);
    bus_phase(1, 32'h2468_ACE0, 32'h6000_0004, 1);
    take_rsp(0, 1'b0);

    // back-to-back reads at the minimum 3-cycle period
    accepts = 0;
    resps = 0;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_sel = 4'hF; cmd_adr = 32'h7000_0000;
    wbm_ack_i = 1'b1; wbm_dat_i = 32'h5555_AAAA; rsp_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (cmd_ready) begin
        accepts++;
        e.err = 1'b0;
        e.dat = 32'h5555_AAAA;
        sb.push_back(e);
      end
      if (rsp_valid && sb.size() > 0) begin
        e = sb.pop_front();
        resps++;
        check("b2b_dat", rsp_dat, e.dat);
        check("b2b_err", 32'(rsp_err), 32'(e.err));
      end
      tick();
    end
    cmd_valid = 1'b0; wbm_ack_i = 1'b0; rsp_ready = 1'b0;
    check("b2b_accepts", 32'(accepts), 32'd3);
    check("b2b_resps", 32'(resps), 32'd3);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
